// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and hex-to-segment decode for the seven-segment
// scan driver.
//   SEG_BLANK   - A2G value with every segment dark (active-low).
//   SEG_PATTERN - active-high {g,f,e,d,c,b,a} pattern per hex nibble.
//   hex2seg()   - nibble to active-low A2G value.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return ~SEG_PATTERN[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_digit_sel.sv
// seg7_scan_driver_digit_sel: scan timing for the display.
// div_cnt counts cycles within a digit slot (0 is the blank cycle), idx selects
// the digit. Both freeze while en is low.
// Ports:
//   clk        in   system clock
//   rstn       in   synchronous active-low reset
//   en         in   advance the scan
//   div_cnt    out  position inside the current slot
//   idx        out  current digit index
//   slot_done  out  one-cycle pulse, registered alongside the idx wrap to 0
module seg7_scan_driver_digit_sel #(
    parameter int  REFRESH_DIV = 100000,
    parameter int  NUM_DIGITS  = 8,
    localparam int DIV_W       = $clog2(REFRESH_DIV),
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic [DIV_W-1:0] div_cnt,
    output logic [IDX_W-1:0] idx,
    output logic             slot_done
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // Explicit terminal-count compares so non-power-of-two sizes wrap correctly.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_cnt   <= '0;
            idx       <= '0;
            slot_done <= 1'b0;
        end else begin
            slot_done <= 1'b0;
            if (en) begin
                if (div_cnt == DIV_MAX) begin
                    div_cnt <= '0;
                    if (idx == IDX_MAX) begin
                        idx       <= '0;
                        slot_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes a shadowed hex value onto a common-anode
// seven-segment display, one blank cycle at the start of every digit slot.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN: blank digits above the most
// significant non-zero nibble (digit 0 always lit).
// Ports:
//   CLK100MHZ  in   system clock
//   RSTN       in   synchronous active-low reset
//   en         in   scan enable; low blanks the display and freezes the scan
//   load       in   strobe capturing value into the shadow register
//   value      in   hex value, digit 0 in value[3:0]
//   AN         out  digit enables, active-low (registered)
//   A2G        out  segments {g,f,e,d,c,b,a}, active-low (registered)
//   slot_done  out  pulse when the last digit slot completes
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                    CLK100MHZ,
    input  logic                    RSTN,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              A2G,
    output logic                    slot_done
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic [NUM_DIGITS-1:0]   digit_on;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;

    seg7_scan_driver_digit_sel #(
        .REFRESH_DIV (REFRESH_DIV),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_digit_sel (
        .clk       (CLK100MHZ),
        .rstn      (RSTN),
        .en        (en),
        .div_cnt   (div_cnt),
        .idx       (idx),
        .slot_done (slot_done)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Scan from the top digit down; once a non-zero nibble is seen every
    // lower digit stays lit.
    always_comb begin
        logic seen;
        seen     = 1'b0;
        digit_on = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen        = seen | (shadow[4*i +: 4] != 4'h0) | (i == 0);
            digit_on[i] = seen;
        end
    end
`else
    always_comb begin
        digit_on = '1;
    end
`endif

    always_comb begin
        an_next  = '1;
        seg_next = SEG_BLANK;
        if (en && (div_cnt != '0) && digit_on[idx]) begin
            an_next  = ~(NUM_DIGITS'(1) << idx);
            seg_next = hex2seg(shadow[4*idx +: 4]);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!RSTN) begin
            shadow <= '0;
            AN     <= '1;
            A2G    <= SEG_BLANK;
        end else begin
            if (load) begin
                shadow <= value;
            end
            AN  <= an_next;
            A2G <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    logic        CLK100MHZ;
    logic        RSTN;
    logic        en;
    logic        load;
    logic [31:0] value;
    logic [7:0]  AN;
    logic [6:0]  A2G;
    logic        slot_done;

    int passed;
    int total;

    seg7_scan_driver #(
        .REFRESH_DIV (4),
        .NUM_DIGITS  (8)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .RSTN      (RSTN),
        .en        (en),
        .load      (load),
        .value     (value),
        .AN        (AN),
        .A2G       (A2G),
        .slot_done (slot_done)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    // Hand-computed tables for value 32'h0000_0408 (digits 8,0,4,0,0,0,0,0).
    logic [7:0] an_tbl  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] seg_408 [8] = '{7'h00, 7'h40, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [7:0] lit_408 = 8'b0000_0111;
`else
    logic [7:0] lit_408 = 8'b1111_1111;
`endif

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic test_reset();
        RSTN  = 1'b0;
        load  = 1'b1;
        en    = 1'b1;
        value = 32'hFFFF_FFFF;
        tick();
        tick();
        total++;
        if (AN !== 8'hFF) $display("FAIL reset_an: got %h want %h", AN, 8'hFF);
        else passed++;
        total++;
        if (A2G !== 7'h7F) $display("FAIL reset_a2g: got %h want %h", A2G, 7'h7F);
        else passed++;
        total++;
        if (slot_done !== 1'b0) $display("FAIL reset_slot_done: got %b want 0", slot_done);
        else passed++;
        // Shadow must still be zero: digit 0 shows "0".
        RSTN = 1'b1;
        load = 1'b0;
        tick();
        total++;
        if (AN !== 8'hFF) $display("FAIL reset_first_blank: got %h want %h", AN, 8'hFF);
        else passed++;
        tick();
        total++;
        if (AN !== 8'hFE || A2G !== 7'h40)
            $display("FAIL reset_shadow_zero: got AN=%h A2G=%h want AN=fe A2G=40", AN, A2G);
        else passed++;
    endtask

    task automatic test_scan_wrap();
        int d;
        int sd_count;
        logic blank;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        RSTN = 1'b0;
        tick();
        RSTN  = 1'b1;
        en    = 1'b0;
        load  = 1'b1;
        value = 32'h0000_0408;
        tick();
        total++;
        if (AN !== 8'hFF) $display("FAIL scan_en_low_load: got %h want ff", AN);
        else passed++;
        load     = 1'b0;
        en       = 1'b1;
        sd_count = 0;
        for (int t = 1; t <= 32; t++) begin
            tick();
            d       = (t - 1) / 4;
            blank   = ((t - 1) % 4 == 0) || !lit_408[d];
            exp_an  = blank ? 8'hFF : an_tbl[d];
            exp_seg = blank ? 7'h7F : seg_408[d];
            if (slot_done === 1'b1) sd_count++;
            total++;
            if (AN !== exp_an || A2G !== exp_seg)
                $display("FAIL scan_t%0d: got AN=%h A2G=%h want AN=%h A2G=%h",
                         t, AN, A2G, exp_an, exp_seg);
            else passed++;
            total++;
            if (slot_done !== (t == 32))
                $display("FAIL slot_done_t%0d: got %b want %b", t, slot_done, (t == 32));
            else passed++;
        end
        total++;
        if (sd_count != 1) $display("FAIL slot_done_count: got %0d want 1", sd_count);
        else passed++;
        tick();
        total++;
        if (AN !== 8'hFF || slot_done !== 1'b0)
            $display("FAIL wrap_blank: got AN=%h sd=%b want AN=ff sd=0", AN, slot_done);
        else passed++;
        tick();
        total++;
        if (AN !== 8'hFE || A2G !== 7'h00)
            $display("FAIL wrap_digit0: got AN=%h A2G=%h want AN=fe A2G=00", AN, A2G);
        else passed++;
    endtask

    task automatic test_mid_load();
        // Digit 0 is lit; state is div=2, idx=0.
        load  = 1'b1;
        value = 32'hFFFF_FFFF;
        tick();
        load = 1'b0;
        tick();
        total++;
        if (AN !== 8'hFE || A2G !== 7'h0E)
            $display("FAIL mid_load: got AN=%h A2G=%h want AN=fe A2G=0e", AN, A2G);
        else passed++;
    endtask

    task automatic test_pause_reset();
        // State is div=0, idx=1; run to div=2, idx=3.
        repeat (10) tick();
        total++;
        if (AN !== 8'hF7 || A2G !== 7'h0E)
            $display("FAIL pause_pre: got AN=%h A2G=%h want AN=f7 A2G=0e", AN, A2G);
        else passed++;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (AN !== 8'hFF || A2G !== 7'h7F || slot_done !== 1'b0)
                $display("FAIL pause_c%0d: got AN=%h A2G=%h sd=%b want AN=ff A2G=7f sd=0",
                         i, AN, A2G, slot_done);
            else passed++;
        end
        en = 1'b1;
        tick();
        total++;
        if (AN !== 8'hF7 || A2G !== 7'h0E)
            $display("FAIL resume_idx3: got AN=%h A2G=%h want AN=f7 A2G=0e", AN, A2G);
        else passed++;
        tick();
        tick();
        total++;
        if (AN !== 8'hFF) $display("FAIL resume_blank: got %h want ff", AN);
        else passed++;
        repeat (5) tick();
        total++;
        if (AN !== 8'hDF) $display("FAIL reach_idx5: got %h want df", AN);
        else passed++;
        RSTN = 1'b0;
        tick();
        total++;
        if (AN !== 8'hFF || A2G !== 7'h7F)
            $display("FAIL midscan_reset: got AN=%h A2G=%h want AN=ff A2G=7f", AN, A2G);
        else passed++;
        RSTN = 1'b1;
        tick();
        total++;
        if (AN !== 8'hFF) $display("FAIL restart_blank: got %h want ff", AN);
        else passed++;
        tick();
        total++;
        if (AN !== 8'hFE || A2G !== 7'h40)
            $display("FAIL restart_digit0: got AN=%h A2G=%h want AN=fe A2G=40", AN, A2G);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        RSTN   = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        value  = '0;
        test_reset();
        test_scan_wrap();
        test_mid_load();
        test_pause_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
